axi4_lite_cmd_master: RTL and testbench
=======================================

// Module: axi4_lite_cmd_master
// PURPOSE
//  Single-outstanding AXI4-Lite master. Turns a simple valid/ready command port into AXI4-Lite
//  transactions and drives the register slave (axi4_lite, gpio_o) from upstream control logic.
//  It also returns the read data / BRESP / RRESP on a valid/ready response port.
// PARAMETERS
//  ADDR_WIDTH      8     AXI address width
//  DATA_WIDTH      32    AXI data width (STRB_WIDTH = DATA_WIDTH/8)
//  TIMEOUT_CYCLES  256   watchdog limit, cycles per transaction (used only with AXI_MST_TIMEOUT_EN)
// PORTS
//  clk            in   1           single clock, all logic posedge
//  rst            in   1           asynchronous, active-high reset
//  cmd_valid      in   1           command present
//  cmd_ready      out  1           command accepted when cmd_valid&&cmd_ready
//  cmd_write      in   1           1=write, 0=read
//  cmd_addr       in   ADDR_WIDTH  target address
//  cmd_wdata      in   DATA_WIDTH  write data
//  cmd_wstrb      in   STRB_WIDTH  write strobes
//  rsp_valid      out  1           response present
//  rsp_ready      in   1           response consumed when rsp_valid&&rsp_ready
//  rsp_rdata      out  DATA_WIDTH  read data (0 for writes)
//  rsp_resp       out  2           BRESP/RRESP; 2'b10 on timeout
//  rsp_write      out  1           echo of cmd_write
//  m_axi_aw{addr,valid,ready} / w{data,strb,valid,ready} / b{resp,valid,ready}
//  m_axi_ar{addr,valid,ready} / r{data,resp,valid,ready}   standard AXI4-Lite master side
//  busy           out  1           FSM not in IDLE
// BEHAVIOUR
//  Reset: every valid out=0, cmd_ready=0 during reset, addr/data/strb regs=0, rsp_*=0, FSM=IDLE.
//  FSM: IDLE -> WRITE -> WAIT_B -> RESP -> IDLE ; IDLE -> READ -> WAIT_R -> RESP -> IDLE.
//  IDLE: cmd_ready=1. On accept, capture all cmd_* into regs.
//   The following cycle, assert awvalid+wvalid (write) or arvalid (read). Capture->valid latency = 1 clk.
//  WRITE: awvalid and wvalid are dropped independently, each on its own handshake (aw_done/w_done flags).
//   Either order or the same cycle is legal. Go to WAIT_B once both are done.
//   bready=1 in WRITE and WAIT_B; a B arriving in the same cycle as the last AW/W handshake goes straight to RESP.
//  READ: arvalid held until arready. rready=1 in READ and WAIT_R. R captured (rdata, rresp) then RESP.
//  RESP: rsp_valid=1, held stable until rsp_ready. On handshake -> IDLE. rsp_valid and cmd_ready are never
//   high in the same cycle, so there is no back-to-back command in the response cycle.
//  VALIDs obey AXI: never deasserted before their ready; address/data stable while valid.
//  No combinational path from any ready input to any valid output.
//  cmd_* changes while busy: ignored; registered copy used.
//  rst mid-transaction: immediate return to IDLE, all valids low. Slave reset is the system's responsibility.
// CONFIGURATION
//  AXI_MST_TIMEOUT_EN defined: a cycle counter clears on command accept and counts in WRITE/WAIT_B/READ/WAIT_R.
//   When it reaches TIMEOUT_CYCLES-1: drop all AXI valids, go to RESP with rsp_resp=2'b10 and rsp_rdata=0,
//   and set sticky output timeout_o (cleared only by rst). This is a hung-slave recovery path only.
//  Macro undefined: no counter and no timeout_o port; the FSM waits indefinitely.
// STRUCTURE
//  Shared package axi4_lite_pkg: resp enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11),
//   master FSM state enum, default ADDR_WIDTH/DATA_WIDTH localparams.
//  Single flat module, no sub-module needed. The timeout counter is inline under `ifdef.
// TESTING
//  Write 0x00=0xDEADBEEF, strb 0xF, slave ready -> awaddr 0x00 / wdata 0xDEADBEEF seen once; rsp_resp=00, rsp_write=1.
//  Read 0x00 after above write -> araddr 0x00; rsp_rdata=0xDEADBEEF, rsp_resp=00.
//  Slave gives awready 3 clk before wready -> awvalid drops first, wvalid held; exactly one AW and one W handshake.
//  rsp_ready held low 5 clk -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout, next cmd accepted after handshake.
//  rst pulsed while in WAIT_R -> all valids 0 within the same cycle; busy=0; next read completes normally.
//  AXI_MST_TIMEOUT_EN, arready tied 0 -> after TIMEOUT_CYCLES cycles arvalid=0; rsp_resp=10 and timeout_o=1.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, master FSM states and default bus widths.
package axi4_lite_pkg;

    localparam int AXI_ADDR_WIDTH = 8;
    localparam int AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_B,
        ST_READ,
        ST_WAIT_R,
        ST_RESP
    } mst_state_e;

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port.
// Optional hung-slave watchdog with sticky timeout_o: define AXI_MST_TIMEOUT_EN.
module axi4_lite_cmd_master
    import axi4_lite_pkg::*;
#(
    parameter  int ADDR_WIDTH     = AXI_ADDR_WIDTH,
    parameter  int DATA_WIDTH     = AXI_DATA_WIDTH,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_write,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
`ifdef AXI_MST_TIMEOUT_EN
    output logic                  timeout_o,
`endif
    output logic                  busy
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    mst_state_e            state_q, state_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_done_q, w_done_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic                  rsp_write_q;

    logic accept, active, tmo_expired;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic ld_b, ld_r, ld_tmo;

    // All AXI valids/readies decode from registered state only, so no ready->valid path exists.
    assign m_axi_awvalid = (state_q == ST_WRITE) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == ST_WRITE) && !w_done_q;
    assign m_axi_bready  = (state_q == ST_WRITE) || (state_q == ST_WAIT_B);
    assign m_axi_arvalid = (state_q == ST_READ);
    assign m_axi_rready  = (state_q == ST_READ) || (state_q == ST_WAIT_R);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_write = rsp_write_q;

    assign accept = cmd_valid && cmd_ready;
    assign active = (state_q == ST_WRITE) || (state_q == ST_WAIT_B) ||
                    (state_q == ST_READ)  || (state_q == ST_WAIT_R);
    assign aw_hs  = m_axi_awvalid && m_axi_awready;
    assign w_hs   = m_axi_wvalid && m_axi_wready;
    assign b_hs   = m_axi_bvalid && m_axi_bready;
    assign ar_hs  = m_axi_arvalid && m_axi_arready;
    assign r_hs   = m_axi_rvalid && m_axi_rready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_b    = 1'b0;
        ld_r    = 1'b0;
        ld_tmo  = 1'b0;
        case (state_q)
            ST_IDLE:   if (accept) state_d = cmd_write ? ST_WRITE : ST_READ;
            ST_WRITE:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                           // A B beat in the same cycle as the final AW/W handshake is taken here.
                           if (b_hs) begin
                               state_d = ST_RESP;
                               ld_b    = 1'b1;
                           end else begin
                               state_d = ST_WAIT_B;
                           end
                       end
            ST_WAIT_B: if (b_hs) begin
                           state_d = ST_RESP;
                           ld_b    = 1'b1;
                       end
            ST_READ:   if (ar_hs) state_d = ST_WAIT_R;
            ST_WAIT_R: if (r_hs) begin
                           state_d = ST_RESP;
                           ld_r    = 1'b1;
                       end
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // Watchdog only fires when the slave has not completed the transaction this cycle.
        if (tmo_expired && (state_d != ST_RESP)) begin
            state_d = ST_RESP;
            ld_tmo  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= OKAY;
            rsp_write_q <= 1'b0;
        end else begin
            if (accept) begin
                write_q   <= cmd_write;
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (ld_tmo) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= SLVERR;
                rsp_write_q <= write_q;
            end else if (ld_b) begin
                rsp_rdata_q <= '0;
                rsp_resp_q  <= m_axi_bresp;
                rsp_write_q <= 1'b1;
            end else if (ld_r) begin
                rsp_rdata_q <= m_axi_rdata;
                rsp_resp_q  <= m_axi_rresp;
                rsp_write_q <= 1'b0;
            end
        end
    end

`ifdef AXI_MST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             timeout_q;

    assign tmo_expired = active && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_o   = timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (accept)      tmo_cnt_q <= '0;
            else if (active) tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (ld_tmo)      timeout_q <= 1'b1;
        end
    end
`else
    assign tmo_expired = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// Randomized bench: behavioural AXI4-Lite slave with per-channel latency knobs plus a memory reference model.
module tb_axi4_lite_cmd_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0, bready;
    logic        arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0, rready;
    logic        busy;
`ifdef AXI_MST_TIMEOUT_EN
    logic        timeout_o;
`endif

    int checks = 0;
    int failures = 0;

    axi4_lite_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
`ifdef AXI_MST_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave: addresses >= 0xF0 answer SLVERR, ignore writes and read as zero.
    logic [31:0] slv_mem [256];
    logic [31:0] ref_mem [256];
    int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
    logic aw_pend = 0, w_pend = 0, b_pend = 0, ar_pend = 0, r_pend = 0;
    logic [7:0]  aw_q = '0, ar_q = '0;
    logic [31:0] wd_q = '0, rd_q = '0;
    logic [3:0]  ws_q = '0;
    logic [1:0]  bresp_q = '0, rresp_q = '0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, aw_hi = 0, w_hi = 0;
    logic [7:0]  last_awaddr = '0, last_araddr = '0;
    logic [31:0] last_wdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        end else begin
            if (awvalid && awready) begin
                aw_pend = 1; aw_q = awaddr; aw_cnt++; aw_wait = 0; last_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                w_pend = 1; wd_q = wdata; ws_q = wstrb; w_cnt++; w_wait = 0; last_wdata = wdata;
            end
            if (bvalid && bready) b_pend = 0;
            if (arvalid && arready) begin
                ar_pend = 1; ar_q = araddr; ar_cnt++; ar_wait = 0; last_araddr = araddr;
            end
            if (rvalid && rready) r_pend = 0;
            if (aw_pend && w_pend && !b_pend) begin
                bresp_q = (aw_q >= 8'hF0) ? 2'b10 : 2'b00;
                if (aw_q < 8'hF0)
                    for (int b = 0; b < 4; b++)
                        if (ws_q[b]) slv_mem[aw_q][8*b +: 8] = wd_q[8*b +: 8];
                aw_pend = 0; w_pend = 0; b_pend = 1; b_wait = 0;
            end
            if (ar_pend && !r_pend) begin
                rresp_q = (ar_q >= 8'hF0) ? 2'b10 : 2'b00;
                rd_q = (ar_q >= 8'hF0) ? 32'h0 : slv_mem[ar_q];
                ar_pend = 0; r_pend = 1; r_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        end else begin
            awready = awvalid && !aw_pend && (aw_wait >= aw_lat);
            wready  = wvalid && !w_pend && (w_wait >= w_lat);
            arready = arvalid && !ar_pend && (ar_wait >= ar_lat);
            aw_wait = awvalid ? aw_wait + 1 : 0;
            w_wait  = wvalid ? w_wait + 1 : 0;
            ar_wait = arvalid ? ar_wait + 1 : 0;
            if (awvalid) aw_hi++;
            if (wvalid) w_hi++;
            bvalid = b_pend && (b_wait >= b_lat);
            bresp  = bresp_q;
            if (b_pend) b_wait++;
            rvalid = r_pend && (r_wait >= r_lat);
            rdata  = rd_q;
            rresp  = rresp_q;
            if (r_pend) r_wait++;
        end
    end

    // AXI rule monitor: a valid not yet accepted must stay high with a stable payload.
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [7:0]  p_awa = '0, p_ara = '0;
    logic [31:0] p_wd = '0;
    always @(posedge clk) begin
        if (rst) begin
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else begin
            if (p_awv && !p_awr) begin
                checks++;
                if (awvalid !== 1'b1 || awaddr !== p_awa) begin
                    failures++;
                    $display("FAIL aw_stable awvalid=%0b awaddr=%h required 1/%h", awvalid, awaddr, p_awa);
                end
            end
            if (p_wv && !p_wr) begin
                checks++;
                if (wvalid !== 1'b1 || wdata !== p_wd) begin
                    failures++;
                    $display("FAIL w_stable wvalid=%0b wdata=%h required 1/%h", wvalid, wdata, p_wd);
                end
            end
            if (p_arv && !p_arr) begin
                checks++;
                if (arvalid !== 1'b1 || araddr !== p_ara) begin
                    failures++;
                    $display("FAIL ar_stable arvalid=%0b araddr=%h required 1/%h", arvalid, araddr, p_ara);
                end
            end
            p_awv = awvalid; p_awr = awready; p_awa = awaddr;
            p_wv = wvalid; p_wr = wready; p_wd = wdata;
            p_arv = arvalid; p_arr = arready; p_ara = araddr;
        end
    end

    task automatic do_cmd(input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold);
        logic [31:0] er, held;
        logic [1:0]  ep;
        int n;
        ep = (a >= 8'hF0) ? 2'b10 : 2'b00;
        er = '0;
        if (w) begin
            if (ep == 2'b00)
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else if (ep == 2'b00) begin
            er = ref_mem[a];
        end
        @(negedge clk);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_accept cmd_ready=%0b required 1", cmd_ready);
            cmd_valid = 0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 0; cmd_write = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = $urandom;
        checks++;
        if (busy !== 1'b1 || (w ? (awvalid !== 1'b1 || wvalid !== 1'b1) : (arvalid !== 1'b1))) begin
            failures++;
            $display("FAIL issue_latency busy=%0b aw=%0b w=%0b ar=%0b write=%0b", busy, awvalid, wvalid, arvalid, w);
        end
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rsp_timeout rsp_valid=%0b required 1", rsp_valid);
            return;
        end
        held = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL rsp_hold valid=%0b rdata=%h cmd_ready=%0b required 1/%h/0", rsp_valid, rsp_rdata, cmd_ready, held);
            end
            @(negedge clk);
        end
        checks++;
        if (rsp_rdata !== er || rsp_resp !== ep || rsp_write !== w) begin
            failures++;
            $display("FAIL rsp_data addr=%h rdata=%h resp=%b write=%0b required %h/%b/%0b", a, rsp_rdata, rsp_resp, rsp_write, er, ep, w);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rsp_release rsp_valid=%0b cmd_ready=%0b busy=%0b required 0/1/0", rsp_valid, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 0 || awvalid !== 0 || wvalid !== 0 || arvalid !== 0 || bready !== 0 ||
            rready !== 0 || rsp_valid !== 0 || busy !== 0 || rsp_rdata !== 0 || rsp_resp !== 0 || rsp_write !== 0) begin
            failures++;
            $display("FAIL reset_state cmd_ready=%0b aw=%0b w=%0b ar=%0b rsp_valid=%0b busy=%0b rdata=%h required all 0",
                     cmd_ready, awvalid, wvalid, arvalid, rsp_valid, busy, rsp_rdata);
        end
        rst = 0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release cmd_ready=%0b required 1", cmd_ready);
        end
`ifdef AXI_MST_TIMEOUT_EN
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_timeout timeout_o=%0b required 0", timeout_o);
        end
`endif
    endtask

    task automatic test_basic_write_read();
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        do_cmd(1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 0);
        checks++;
        if (aw_cnt !== 1 || w_cnt !== 1 || last_awaddr !== 8'h00 || last_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_write aw_cnt=%0d w_cnt=%0d awaddr=%h wdata=%h required 1/1/00/deadbeef", aw_cnt, w_cnt, last_awaddr, last_wdata);
        end
        do_cmd(1'b0, 8'h00, 32'h0, 4'h0, 0);
        checks++;
        if (ar_cnt !== 1 || last_araddr !== 8'h00) begin
            failures++;
            $display("FAIL basic_read ar_cnt=%0d araddr=%h required 1/00", ar_cnt, last_araddr);
        end
        do_cmd(1'b1, 8'h00, 32'h11223344, 4'b0101, 0);
        do_cmd(1'b0, 8'h00, 32'h0, 4'h0, 0);
        do_cmd(1'b1, 8'hF4, 32'hCAFEF00D, 4'hF, 0);
        do_cmd(1'b0, 8'hF4, 32'h0, 4'h0, 0);
    endtask

    task automatic test_aw_before_w();
        aw_cnt = 0; w_cnt = 0; aw_hi = 0; w_hi = 0;
        aw_lat = 0; w_lat = 3;
        do_cmd(1'b1, 8'h05, 32'hA5A5_5A5A, 4'hF, 0);
        checks++;
        if (aw_cnt !== 1 || w_cnt !== 1 || aw_hi !== 1 || w_hi !== 4) begin
            failures++;
            $display("FAIL aw_before_w aw_cnt=%0d w_cnt=%0d aw_cycles=%0d w_cycles=%0d required 1/1/1/4", aw_cnt, w_cnt, aw_hi, w_hi);
        end
        aw_cnt = 0; w_cnt = 0; aw_hi = 0; w_hi = 0;
        aw_lat = 2; w_lat = 0;
        do_cmd(1'b1, 8'h06, 32'h0BAD_F00D, 4'hF, 0);
        checks++;
        if (aw_cnt !== 1 || w_cnt !== 1 || aw_hi !== 3 || w_hi !== 1) begin
            failures++;
            $display("FAIL w_before_aw aw_cnt=%0d w_cnt=%0d aw_cycles=%0d w_cycles=%0d required 1/1/3/1", aw_cnt, w_cnt, aw_hi, w_hi);
        end
        aw_lat = 0; w_lat = 0;
    endtask

    task automatic test_rsp_backpressure();
        do_cmd(1'b0, 8'h05, 32'h0, 4'h0, 5);
        do_cmd(1'b1, 8'h07, 32'h7777_0001, 4'hF, 5);
        do_cmd(1'b0, 8'h07, 32'h0, 4'h0, 0);
    endtask

    task automatic test_reset_mid();
        int n;
        r_lat = 40;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h05;
        @(posedge clk); #1;
        cmd_valid = 0;
        n = 0;
        @(negedge clk);
        while (!(busy && !arvalid) && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!(busy === 1'b1 && arvalid === 1'b0 && rready === 1'b1)) begin
            failures++;
            $display("FAIL reach_wait_r busy=%0b arvalid=%0b rready=%0b required 1/0/1", busy, arvalid, rready);
        end
        rst = 1;
        #1;
        checks++;
        if (awvalid !== 0 || wvalid !== 0 || arvalid !== 0 || rready !== 0 || bready !== 0 ||
            rsp_valid !== 0 || busy !== 0 || cmd_ready !== 0) begin
            failures++;
            $display("FAIL reset_mid aw=%0b w=%0b ar=%0b rready=%0b rsp_valid=%0b busy=%0b cmd_ready=%0b required all 0",
                     awvalid, wvalid, arvalid, rready, rsp_valid, busy, cmd_ready);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        r_lat = 0;
        do_cmd(1'b0, 8'h05, 32'h0, 4'h0, 0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
            b_lat = $urandom_range(0, 3);  r_lat = $urandom_range(0, 3);
            a = ($urandom_range(0, 7) == 0) ? 8'(8'hF0 + $urandom_range(0, 15)) : 8'($urandom_range(0, 7));
            do_cmd(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end
        aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;
    endtask

`ifdef AXI_MST_TIMEOUT_EN
    task automatic test_timeout();
        int n, ar_cyc;
        ar_lat = 1000000;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h03;
        @(posedge clk); #1;
        cmd_valid = 0;
        n = 0; ar_cyc = 0;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin
            if (arvalid) ar_cyc++;
            @(negedge clk); n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || ar_cyc !== TMO || arvalid !== 1'b0 || rsp_resp !== 2'b10 ||
            rsp_rdata !== 32'h0 || timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout rsp_valid=%0b ar_cycles=%0d arvalid=%0b resp=%b rdata=%h timeout_o=%0b required 1/%0d/0/10/0/1",
                     rsp_valid, ar_cyc, arvalid, rsp_resp, rsp_rdata, timeout_o, TMO);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        ar_lat = 0;
        do_cmd(1'b0, 8'h05, 32'h0, 4'h0, 0);
        checks++;
        if (timeout_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky timeout_o=%0b required 1", timeout_o);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_basic_write_read();
        test_aw_before_w();
        test_rsp_backpressure();
        test_reset_mid();
        test_random();
`ifdef AXI_MST_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
